// File: rtl/bsg_manycore_ruche_x_link_buffer.sv
// bsg_manycore_ruche_x_link_buffer
//   Register slice for one ruche-X link between two horizontal ruche stops.
//   Side A faces the router, side B faces the pod. Each of the four channels
//   (fwd A->B, fwd B->A, rev A->B, rev B->A) passes through its own 2-entry
//   FIFO, so the long wires are cut without losing throughput. Each channel
//   also has a saturating count of the packets it accepts.
//
//   Link layout, MSB first:
//     {fwd_v, fwd_ready_and_rev, fwd_data, rev_v, rev_ready_and_rev, rev_data}
//
//   Ports
//     clk_i          clock, rising edge
//     reset_n_i      asynchronous active-low reset
//     link_a_i/o     side-A ruche link in/out
//     link_b_i/o     side-B ruche link in/out
//     count_clear_i  synchronous clear of all counters
//     count_o        {rev B->A, rev A->B, fwd B->A, fwd A->B} counters

// One channel: 2-entry FIFO plus a saturating enqueue counter.
//   en_i gates ready so that ready stays low while reset is asserted.
module bsg_manycore_ruche_x_link_buffer_chan #(
  parameter int width_p       = 8,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     en_i,
  input  logic                     v_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_and_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     ready_and_i,
  input  logic                     count_clear_i,
  output logic [count_width_p-1:0] count_o
);

  logic [1:0][width_p-1:0] mem;
  logic wptr_r, rptr_r, full_r, empty_r;
  logic enq, deq;
  logic [count_width_p-1:0] count_r;

  // Both handshake outputs come from flops only.
  assign ready_and_o = en_i & ~full_r;
  assign v_o         = ~empty_r;
  assign data_o      = mem[rptr_r];

  assign enq = v_i & ready_and_o;
  assign deq = v_o & ready_and_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (enq) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
      // enq alone: 0->1 or 1->2 entries; deq alone: 2->1 or 1->0.
      // enq+deq together only happens at 1 entry and leaves the flags alone.
      if (enq && !deq) begin
        empty_r <= 1'b0;
        full_r  <= ~empty_r;
      end else if (deq && !enq) begin
        full_r  <= 1'b0;
        empty_r <= ~full_r;
      end
    end
  end

  // Storage is not reset; empty_r masks stale contents.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)            count_r <= '0;
    else if (count_clear_i)    count_r <= '0;
    else if (enq && !(&count_r)) count_r <= count_r + count_width_p'(1);
  end

  assign count_o = count_r;

endmodule

module bsg_manycore_ruche_x_link_buffer #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int count_width_p  = 16,
  // fwd packet: op, op_ex, reg_id (11b) + addr + payload + dst/src x,y
  localparam int fwd_width_lp = 11 + addr_width_p + data_width_p
                                + 2*(x_cord_width_p + y_cord_width_p),
  // rev packet: type, reg_id (7b) + data + dst x,y
  localparam int rev_width_lp = 7 + data_width_p + x_cord_width_p + y_cord_width_p,
  localparam int ruche_x_link_sif_width_lp = fwd_width_lp + rev_width_lp + 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [ruche_x_link_sif_width_lp-1:0] link_a_i,
  output logic [ruche_x_link_sif_width_lp-1:0] link_a_o,
  input  logic [ruche_x_link_sif_width_lp-1:0] link_b_i,
  output logic [ruche_x_link_sif_width_lp-1:0] link_b_o,
  input  logic                                 count_clear_i,
  output logic [4*count_width_p-1:0]           count_o
);

  typedef struct packed {
    logic                    fwd_v;
    logic                    fwd_ready_and_rev;
    logic [fwd_width_lp-1:0] fwd_data;
    logic                    rev_v;
    logic                    rev_ready_and_rev;
    logic [rev_width_lp-1:0] rev_data;
  } link_s;

  link_s a_in, b_in, a_out, b_out;
  assign a_in     = link_a_i;
  assign b_in     = link_b_i;
  assign link_a_o = a_out;
  assign link_b_o = b_out;

  // Channel index: 0 fwd A->B, 1 fwd B->A, 2 rev A->B, 3 rev B->A.
  logic [3:0] enq_v, enq_ready, deq_v, deq_ready;
  logic [1:0][fwd_width_lp-1:0] fwd_enq_data, fwd_deq_data;
  logic [1:0][rev_width_lp-1:0] rev_enq_data, rev_deq_data;
  logic [3:0][count_width_p-1:0] count;
  logic ready_en_r;

  // Ready is forced low throughout reset and comes up on the first edge after.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ready_en_r <= 1'b0;
    else            ready_en_r <= 1'b1;
  end

  assign enq_v     = {b_in.rev_v, a_in.rev_v, b_in.fwd_v, a_in.fwd_v};
  assign deq_ready = {a_in.rev_ready_and_rev, b_in.rev_ready_and_rev,
                      a_in.fwd_ready_and_rev, b_in.fwd_ready_and_rev};
  assign fwd_enq_data = {b_in.fwd_data, a_in.fwd_data};
  assign rev_enq_data = {b_in.rev_data, a_in.rev_data};

  assign a_out = '{fwd_v: deq_v[1], fwd_ready_and_rev: enq_ready[0], fwd_data: fwd_deq_data[1],
                   rev_v: deq_v[3], rev_ready_and_rev: enq_ready[2], rev_data: rev_deq_data[1]};
  assign b_out = '{fwd_v: deq_v[0], fwd_ready_and_rev: enq_ready[1], fwd_data: fwd_deq_data[0],
                   rev_v: deq_v[2], rev_ready_and_rev: enq_ready[3], rev_data: rev_deq_data[0]};

  for (genvar i = 0; i < 2; i++) begin : fwd
    bsg_manycore_ruche_x_link_buffer_chan #(
      .width_p(fwd_width_lp), .count_width_p(count_width_p)
    ) ch (
      .clk_i, .reset_n_i, .en_i(ready_en_r),
      .v_i(enq_v[i]), .data_i(fwd_enq_data[i]), .ready_and_o(enq_ready[i]),
      .v_o(deq_v[i]), .data_o(fwd_deq_data[i]), .ready_and_i(deq_ready[i]),
      .count_clear_i, .count_o(count[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : rev
    bsg_manycore_ruche_x_link_buffer_chan #(
      .width_p(rev_width_lp), .count_width_p(count_width_p)
    ) ch (
      .clk_i, .reset_n_i, .en_i(ready_en_r),
      .v_i(enq_v[2+i]), .data_i(rev_enq_data[i]), .ready_and_o(enq_ready[2+i]),
      .v_o(deq_v[2+i]), .data_o(rev_deq_data[i]), .ready_and_i(deq_ready[2+i]),
      .count_clear_i, .count_o(count[2+i])
    );
  end

  assign count_o = count;

endmodule

// File: tb/tb_bsg_manycore_ruche_x_link_buffer.sv
// Directed + scoreboarded bench for bsg_manycore_ruche_x_link_buffer.
// A second instance with 4-bit counters covers saturation and clear.
module tb_bsg_manycore_ruche_x_link_buffer;

  localparam int AW = 8, DW = 16, XW = 2, YW = 2, CW = 16, N = 1000;
  localparam int FW = 11 + AW + DW + 2*(XW + YW);  // 43
  localparam int RW = 7 + DW + XW + YW;            // 27

  typedef struct packed {
    logic          fwd_v;
    logic          fwd_rdy;
    logic [FW-1:0] fwd_d;
    logic          rev_v;
    logic          rev_rdy;
    logic [RW-1:0] rev_d;
  } link_t;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, s_clr = 1'b0;
  always #5 clk = ~clk;

  // Per-channel view: 0 fwd A->B, 1 fwd B->A, 2 rev A->B, 3 rev B->A
  logic        src_v [4];
  logic [63:0] src_d [4];
  logic        snk_rdy [4];
  logic        in_rdy [4];
  logic        out_v [4];
  logic [63:0] out_d [4];

  link_t la, lb, oa, ob;
  logic [4*CW-1:0] cnt;
  link_t s_la, s_lb, s_oa, s_ob;
  logic [15:0] s_cnt;

  always_comb begin
    la = '0; lb = '0;
    la.fwd_v = src_v[0]; la.fwd_d = src_d[0][FW-1:0]; la.fwd_rdy = snk_rdy[1];
    la.rev_v = src_v[2]; la.rev_d = src_d[2][RW-1:0]; la.rev_rdy = snk_rdy[3];
    lb.fwd_v = src_v[1]; lb.fwd_d = src_d[1][FW-1:0]; lb.fwd_rdy = snk_rdy[0];
    lb.rev_v = src_v[3]; lb.rev_d = src_d[3][RW-1:0]; lb.rev_rdy = snk_rdy[2];
  end

  always_comb begin
    in_rdy[0] = oa.fwd_rdy; in_rdy[1] = ob.fwd_rdy;
    in_rdy[2] = oa.rev_rdy; in_rdy[3] = ob.rev_rdy;
    out_v[0] = ob.fwd_v; out_d[0] = 64'(ob.fwd_d);
    out_v[1] = oa.fwd_v; out_d[1] = 64'(oa.fwd_d);
    out_v[2] = ob.rev_v; out_d[2] = 64'(ob.rev_d);
    out_v[3] = oa.rev_v; out_d[3] = 64'(oa.rev_d);
  end

  bsg_manycore_ruche_x_link_buffer #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .count_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .link_a_i(la), .link_a_o(oa), .link_b_i(lb), .link_b_o(ob),
    .count_clear_i(clr), .count_o(cnt)
  );

  bsg_manycore_ruche_x_link_buffer #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .count_width_p(4)
  ) dut_s (
    .clk_i(clk), .reset_n_i(rst_n),
    .link_a_i(s_la), .link_a_o(s_oa), .link_b_i(s_lb), .link_b_o(s_ob),
    .count_clear_i(s_clr), .count_o(s_cnt)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cnt_of(input int c);
    return 64'(cnt[c*CW +: CW]);
  endfunction

  function automatic logic [63:0] mask(input int c);
    return (c < 2) ? ((64'd1 << FW) - 64'd1) : ((64'd1 << RW) - 64'd1);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int sent [4], rcvd [4];
  logic took [4];
  logic [63:0] q [4][$];
  logic done;
  int cyc;

  initial begin
    for (int c = 0; c < 4; c++) begin
      src_v[c] = 1'b0; src_d[c] = '0; snk_rdy[c] = 1'b0;
      sent[c] = 0; rcvd[c] = 0; took[c] = 1'b0;
    end
    s_la = '0; s_lb = '0;

    // ---- reset state ----
    #12;
    chk("rst_v", 64'(out_v[0]), 64'd0);
    chk("rst_rdy_held", 64'(in_rdy[0]), 64'd0);
    chk("rst_cnt", cnt, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rdy_before_edge", 64'(in_rdy[0]), 64'd0);
    tick();
    for (int c = 0; c < 4; c++) chk($sformatf("rdy_after_rst%0d", c), 64'(in_rdy[c]), 64'd1);

    // ---- single packet fwd A->B ----
    snk_rdy[0] = 1'b1; src_v[0] = 1'b1; src_d[0] = 64'h1234;
    #1 chk("no_bypass", 64'(out_v[0]), 64'd0);
    tick();
    src_v[0] = 1'b0;
    chk("single_v", 64'(out_v[0]), 64'd1);
    chk("single_d", out_d[0], 64'h1234);
    chk("single_cnt", cnt_of(0), 64'd1);
    tick();
    chk("single_v_once", 64'(out_v[0]), 64'd0);

    // ---- backpressure rev B->A ----
    snk_rdy[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      src_v[3] = 1'b1; src_d[3] = 64'hA0 + 64'(k);
      chk($sformatf("bp_rdy%0d", k), 64'(in_rdy[3]), (k < 2) ? 64'd1 : 64'd0);
      tick();
    end
    chk("bp_cnt2", cnt_of(3), 64'd2);
    chk("bp_head0", out_d[3], 64'hA0);
    snk_rdy[3] = 1'b1;             // A2 still offered, but ready is 0 this cycle
    tick();
    chk("bp_head1", out_d[3], 64'hA1);
    chk("bp_cnt_still2", cnt_of(3), 64'd2);
    chk("bp_rdy_freed", 64'(in_rdy[3]), 64'd1);
    tick();
    src_v[3] = 1'b0;
    chk("bp_head2", out_d[3], 64'hA2);
    chk("bp_cnt3", cnt_of(3), 64'd3);
    tick();
    chk("bp_drained", 64'(out_v[3]), 64'd0);

    // ---- reset mid-stream ----
    snk_rdy[0] = 1'b0; src_v[0] = 1'b1; src_d[0] = 64'h55;
    tick();
    src_d[0] = 64'h66;
    tick();
    src_v[0] = 1'b0;
    chk("mid_v_before", 64'(out_v[0]), 64'd1);
    chk("mid_cnt_before", cnt_of(0), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_v_async", 64'(out_v[0]), 64'd0);
    chk("mid_cnt_async", cnt_of(0), 64'd0);
    chk("mid_rdy_low", 64'(in_rdy[0]), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rdy_back", 64'(in_rdy[0]), 64'd1);
    snk_rdy[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("mid_no_stale", 64'(out_v[0]), 64'd0);
      tick();
    end

    // ---- streaming all four channels ----
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_all", cnt, 64'd0);
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 20000) begin
      for (int c = 0; c < 4; c++) begin
        if (!src_v[c] || took[c]) begin
          if (sent[c] < N) begin
            src_v[c] = 1'b1;
            src_d[c] = {$urandom, $urandom} & mask(c);
          end else src_v[c] = 1'b0;
        end
        snk_rdy[c] = ($urandom_range(99) < 70);
      end
      #1;
      for (int c = 0; c < 4; c++) begin
        took[c] = src_v[c] && in_rdy[c];
        if (took[c]) begin
          q[c].push_back(src_d[c]);
          sent[c]++;
        end
        if (out_v[c] && snk_rdy[c]) begin
          if (q[c].size() == 0) chk($sformatf("stream_extra%0d", c), 64'd1, 64'd0);
          else chk($sformatf("stream_d%0d", c), out_d[c], q[c].pop_front());
          rcvd[c]++;
        end
      end
      done = (rcvd[0] >= N) && (rcvd[1] >= N) && (rcvd[2] >= N) && (rcvd[3] >= N);
      cyc++;
      tick();
    end
    for (int c = 0; c < 4; c++) begin src_v[c] = 1'b0; snk_rdy[c] = 1'b0; end
    chk("stream_done", 64'(done), 64'd1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("stream_cnt%0d", c), cnt_of(c), 64'(sent[c]));
      chk($sformatf("stream_left%0d", c), 64'(q[c].size()), 64'd0);
    end

    // ---- saturation and clear, 4-bit counters, fwd B->A ----
    s_la.fwd_rdy = 1'b1;
    s_lb.fwd_v   = 1'b1;
    s_lb.fwd_d   = FW'(64'h77);
    repeat (15) tick();
    chk("sat_15", 64'(s_cnt[7:4]), 64'd15);
    repeat (5) tick();
    chk("sat_hold", 64'(s_cnt[7:4]), 64'd15);
    chk("sat_other", 64'({s_cnt[15:8], s_cnt[3:0]}), 64'd0);
    chk("sat_rdy", 64'(s_ob.fwd_rdy), 64'd1);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    chk("clr_prio", 64'(s_cnt[7:4]), 64'd0);
    tick();
    s_lb.fwd_v = 1'b0;
    chk("post_clr", 64'(s_cnt[7:4]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
